ula_controlador: RTL

Sequencing controller for the 4-bit `ula` datapath (AND, OR, NOT(A), NAND, SOMA, SUB). It accepts commands over a valid/ready handshake, drives the `ula` operands and `seletor` from internal registers, and iterates an operation 1–4 times with the result fed back into operand A. It keeps an accumulator across commands and returns each result with zero/error flags over a second valid/ready handshake. The block sits between a command source (test sequencer or simple CPU front end) and one internal `ula` instance.

---
 rtl/ula_controlador.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ula_controlador.sv
// ---------------------------------------------------------------------------
// ula_controlador
//   Sequencing controller around one 4-bit `ula` datapath. A command is taken
//   over a valid/ready handshake. The selected operation is then iterated
//   cmd_rep+1 times, and each iteration's result is fed back into operand A.
//   A persistent accumulator tracks every ula result. The final result is
//   returned with zero/error flags over a second valid/ready handshake.
//
//   Handshake semantics (both channels): a transfer happens on a rising edge
//   where valid and ready are both 1. The producer holds valid and its data
//   stable until that edge. Ready never depends on the same channel's valid.
//
//   Ports
//     clk, rst           : clock, synchronous active-high reset
//     cmd_valid/ready    : command handshake
//     cmd_op             : ula seletor (110/111 invalid)
//     cmd_usa_acc        : operand A comes from the accumulator when 1
//     cmd_a, cmd_b       : explicit operand A, operand B
//     cmd_rep            : iterations minus one
//     res_valid/ready    : result handshake
//     resultado,zero,erro: result, result==0, invalid-op flag
//     acc                : live accumulator
//     ocupado            : registered state is not OCIOSO
//     estado_dbg         : raw FSM state for observation
// ---------------------------------------------------------------------------

// ula: 4-bit combinational datapath. Arithmetic wraps modulo 16.
module ula (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [2:0] seletor,
   output logic [3:0] saida
);
   always_comb begin
      saida = 4'b0000;
      case (seletor)
         3'b000:  saida = a & b;
         3'b001:  saida = a | b;
         3'b010:  saida = ~a;
         3'b011:  saida = ~(a & b);
         3'b100:  saida = a + b;
         3'b101:  saida = a - b;
         default: saida = 4'b0000;
      endcase
   end
endmodule

module ula_controlador #(
   parameter int REP_BITS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [2:0]          cmd_op,
   input  logic                cmd_usa_acc,
   input  logic [3:0]          cmd_a,
   input  logic [3:0]          cmd_b,
   input  logic [REP_BITS-1:0] cmd_rep,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [3:0]          resultado,
   output logic                zero,
   output logic                erro,
   output logic [3:0]          acc,
   output logic                ocupado,
   output logic [1:0]          estado_dbg
);
   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      EXECUTA  = 2'd1,
      RESPOSTA = 2'd2
   } estado_t;

   estado_t             state_q, state_d;
   logic [2:0]          op_reg_q, op_reg_d;
   logic [3:0]          op_a_q, op_a_d;
   logic [3:0]          op_b_q, op_b_d;
   logic [REP_BITS-1:0] cnt_q, cnt_d;
   logic [3:0]          acc_q, acc_d;
   logic [3:0]          resultado_q, resultado_d;
   logic                zero_q, zero_d;
   logic                erro_q, erro_d;
   logic [3:0]          ula_out;
   logic                op_valida;

   ula u_ula (
      .a       (op_a_q),
      .b       (op_b_q),
      .seletor (op_reg_q),
      .saida   (ula_out)
   );

   assign op_valida = (cmd_op <= 3'b101);

   // State register. Reset aborts any command in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= OCIOSO;
         op_reg_q    <= 3'b000;
         op_a_q      <= 4'b0000;
         op_b_q      <= 4'b0000;
         cnt_q       <= '0;
         acc_q       <= 4'b0000;
         resultado_q <= 4'b0000;
         zero_q      <= 1'b0;
         erro_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_reg_q    <= op_reg_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         resultado_q <= resultado_d;
         zero_q      <= zero_d;
         erro_q      <= erro_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      op_reg_d    = op_reg_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      resultado_d = resultado_q;
      zero_d      = zero_q;
      erro_d      = erro_q;
      case (state_q)
         OCIOSO: begin
            // cmd_ready is 1 here whenever rst is low, and rst overrides
            // the register update, so cmd_valid alone marks an accept.
            if (cmd_valid) begin
               op_reg_d = cmd_op;
               op_a_d   = cmd_usa_acc ? acc_q : cmd_a;
               op_b_d   = cmd_b;
               cnt_d    = cmd_rep;
               if (op_valida) begin
                  state_d = EXECUTA;
               end else begin
                  // Invalid op: report the untouched accumulator.
                  state_d     = RESPOSTA;
                  resultado_d = acc_q;
                  zero_d      = (acc_q == 4'b0000);
                  erro_d      = 1'b1;
               end
            end
         end
         EXECUTA: begin
            acc_d  = ula_out;
            op_a_d = ula_out;
            if (cnt_q == '0) begin
               resultado_d = ula_out;
               zero_d      = (ula_out == 4'b0000);
               erro_d      = 1'b0;
               state_d     = RESPOSTA;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESPOSTA: begin
            if (res_ready) state_d = OCIOSO;
         end
         default: state_d = OCIOSO;
      endcase
   end

   // Outputs.
   always_comb begin
      cmd_ready  = (state_q == OCIOSO) && !rst;
      res_valid  = (state_q == RESPOSTA);
      ocupado    = (state_q != OCIOSO);
      estado_dbg = state_q;
      resultado  = resultado_q;
      zero       = zero_q;
      erro       = erro_q;
      acc        = acc_q;
   end
endmodule
